vreg_wb_arbiter: RTL and testbench
==================================

# vreg_wb_arbiter

Write-back arbiter for the 32-entry x 32-bit vector register file's single write port. It accepts write requests from three producers through valid/ready handshakes: 0 = vector ALU, 1 = vector load unit, 2 = scalar-to-vector move. It grants one request per cycle in round-robin order and drives the register file's `reg_write`/`write_reg`/`write_data` inputs from a one-entry output register. It also exports a pending-write mask so the issue logic can stall readers of a register whose write has not yet committed.

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register index width (32 registers)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `hold`  in  1  when 1, no new grants; the output stage still drains
- `req_valid`  in  3  per-requester request valid; bit i = requester i
- `req_ready`  out  3  per-requester grant; at most one bit set
- `req_addr0`/`req_addr1`/`req_addr2`  in  ADDR_W each  destination register
- `req_data0`/`req_data1`/`req_data2`  in  DATA_W each  write data
- `reg_write`  out  1  register-file write enable
- `write_reg`  out  ADDR_W  register-file write index
- `write_data`  out  DATA_W  register-file write data
- `pend_mask`  out  32  bit r = 1 while a write to register r sits in the output stage
- `grant_id`  out  2  index of the requester granted this cycle; 3 = none

## Operation
- Handshake: transfer occurs on a cycle where `req_valid[i]` and `req_ready[i]` are both 1.
  - A requester holds valid/addr/data stable until the transfer.
  - `req_valid` must not depend combinationally on `req_ready`.
- Round-robin pointer `rr_ptr` (2 bits, values 0..2).
  - Search order is `rr_ptr`, `rr_ptr+1`, `rr_ptr+2` mod 3.
  - The first requester with valid=1 is granted.
  - After a transfer, `rr_ptr` = granted index + 1 mod 3. With no transfer, `rr_ptr` is unchanged.
- `req_ready` is all zeros when `hold`=1, when `rst`=1, or when no request is valid.
  - The output stage is always free (one write per cycle), so a grant never waits on back-pressure.
- Output stage (`ob_valid`, `ob_addr`, `ob_data`) loads the transferred addr/data at the edge ending the transfer cycle. It clears when there is no transfer.
- `reg_write` = `ob_valid` AND (`ob_addr` != 0).
  - Writes to register 0 are accepted (ready asserted) and then dropped, because register 0 reads as zero.
- `write_reg`/`write_data` always reflect `ob_addr`/`ob_data`, and are 0 after reset.
- `pend_mask` = one-hot(`ob_addr`) when `reg_write`=1, else 0. It is registered and decoded from the output stage.
- Two requesters targeting the same register in consecutive cycles commit in grant order; the later write wins.
- Width rules: no arithmetic on data; the pointer increment wraps 2 -> 0 and never reaches 3.

## Timing
- Reset values (cycle after `rst` sampled high):
  - `rr_ptr`=0, `ob_valid`=0, `ob_addr`=0, `ob_data`=0
  - hence `reg_write`=0, `write_reg`=0, `write_data`=0, `pend_mask`=0
- During `rst`=1: `req_ready`=0 and `grant_id`=3.
- `req_ready` and `grant_id` are combinational from `req_valid`, `hold`, `rst` and `rr_ptr`, with no sequential latency.
- Latency:
  - Transfer in cycle N -> `reg_write`=1 and `pend_mask` bit set during cycle N+1.
  - The register file commits at the end of N+1.
  - The data is readable from the register file in cycle N+2.
- Throughput: one write per cycle sustained. All three requesters continuously valid -> grants follow 0,1,2,0,1,2...
- `hold` asserted in cycle N: no grant in N. A write transferred in N-1 still appears in N.
- Reset mid-operation: a write held in the output stage is discarded (never written); pointer returns to 0.

## Test plan
- Reset: assert `rst` 2 cycles with all `req_valid`=1 -> `req_ready`=000, `reg_write`=0, `pend_mask`=0, `grant_id`=3 throughout.
- Single write: requester 1 valid, addr 7, data 0xDEADBEEF in cycle N -> `req_ready`=010 in N. In N+1: `reg_write`=1, `write_reg`=7, `write_data`=0xDEADBEEF, `pend_mask`=0x00000080. In N+2: `reg_write`=0, `pend_mask`=0.
- Round-robin fairness: all three valid for 6 cycles from reset -> `grant_id` sequence 0,1,2,0,1,2. Then only requesters 0 and 2 valid with `rr_ptr`=0 -> grants 0,2,0.
- Register-0 drop: requester 2 writes addr 0, data 0x12345678 -> `req_ready[2]`=1 in N; in N+1 `reg_write`=0 and `pend_mask`=0.
- Hold and drain: grant to requester 0 (addr 3) in N, `hold`=1 in N+1..N+3 with all valid -> `reg_write`=1 only in N+1. No ready in N+1..N+3. On release in N+4, the grant goes to requester 1.
- Reset mid-flight: transfer addr 5 in N, `rst`=1 in N+1 -> `reg_write`=0 in N+2, register 5 unmodified, pointer back to 0 (next grant with all valid = requester 0).

Source files
------------

// File: rtl/vreg_wb_if.sv
// vreg_wb_if: requester handshakes and register-file write port of the write-back arbiter
interface vreg_wb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [2:0]        req_valid;
   logic [2:0]        req_ready;
   logic [ADDR_W-1:0] req_addr0;
   logic [ADDR_W-1:0] req_addr1;
   logic [ADDR_W-1:0] req_addr2;
   logic [DATA_W-1:0] req_data0;
   logic [DATA_W-1:0] req_data1;
   logic [DATA_W-1:0] req_data2;
   logic              reg_write;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_data;
   logic [31:0]       pend_mask;
   logic [1:0]        grant_id;
   modport master (
      output req_valid, req_addr0, req_addr1, req_addr2, req_data0, req_data1, req_data2,
      input  req_ready, reg_write, write_reg, write_data, pend_mask, grant_id
   );
   modport slave (
      input  req_valid, req_addr0, req_addr1, req_addr2, req_data0, req_data1, req_data2,
      output req_ready, reg_write, write_reg, write_data, pend_mask, grant_id
   );
endinterface

// File: rtl/vreg_wb_arbiter.sv
// vreg_wb_arbiter: round-robin arbiter of three producers onto the vector register file write port
module vreg_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input logic      clk,
   input logic      rst,
   input logic      hold,
   vreg_wb_if.slave bus
);
   logic [1:0]        rr_ptr, c0, c1, c2, gnt;
   logic [3:0]        v;
   logic              xfer;
   logic [ADDR_W-1:0] g_addr, ob_addr;
   logic [DATA_W-1:0] g_data, ob_data;
   logic              ob_valid;
   // search from rr_ptr onward; grant id 3 means nobody, which also shifts ready to zero
   always_comb begin
      v      = {1'b0, bus.req_valid};
      c0     = rr_ptr;
      c1     = rr_ptr == 2'd2 ? 2'd0 : rr_ptr + 2'd1;
      c2     = rr_ptr == 2'd0 ? 2'd2 : rr_ptr - 2'd1;
      gnt    = (rst || hold) ? 2'd3 : v[c0] ? c0 : v[c1] ? c1 : v[c2] ? c2 : 2'd3;
      xfer   = gnt != 2'd3;
      g_addr = gnt == 2'd0 ? bus.req_addr0 : gnt == 2'd1 ? bus.req_addr1 : bus.req_addr2;
      g_data = gnt == 2'd0 ? bus.req_data0 : gnt == 2'd1 ? bus.req_data1 : bus.req_data2;
   end
   assign bus.req_ready = 3'b001 << gnt;
   assign bus.grant_id  = gnt;
   // output stage takes the granted write and empties on idle cycles; pointer moves past the winner
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= 2'd0;
         ob_valid <= 1'b0;
         ob_addr  <= '0;
         ob_data  <= '0;
      end else begin
         ob_valid <= xfer;
         ob_addr  <= xfer ? g_addr : '0;
         ob_data  <= xfer ? g_data : '0;
         if (xfer) rr_ptr <= gnt == 2'd2 ? 2'd0 : gnt + 2'd1;
      end
   end
   // a write caught in the output stage while reset is high is suppressed so it never commits
   assign bus.reg_write  = ob_valid && (ob_addr != '0) && !rst;
   assign bus.write_reg  = ob_addr;
   assign bus.write_data = ob_data;
   assign bus.pend_mask  = bus.reg_write ? 32'd1 << ob_addr : 32'd0;
endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// tb_vreg_wb_arbiter: directed checks of grant order, output stage, hold and reset behaviour
module tb_vreg_wb_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hold = 1'b0;
   int checks = 0;
   int errors = 0;
   vreg_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();
   vreg_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .hold(hold), .bus(bus));
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid = 3'b111;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL rst_ready got %b exp 000", bus.req_ready); end
         checks++; if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL rst_grant got %0d exp 3", bus.grant_id); end
         checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL rst_reg_write got %b exp 0", bus.reg_write); end
         checks++; if (bus.pend_mask !== 32'h0) begin errors++; $display("FAIL rst_pend got %h exp 0", bus.pend_mask); end
         step();
      end
      rst = 1'b0;
      bus.req_valid = 3'b000;
      #1;
      checks++; if (bus.write_reg !== 5'd0) begin errors++; $display("FAIL rst_write_reg got %0d exp 0", bus.write_reg); end
      checks++; if (bus.write_data !== 32'h0) begin errors++; $display("FAIL rst_write_data got %h exp 0", bus.write_data); end
      checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL rst_after_reg_write got %b exp 0", bus.reg_write); end
      checks++; if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL idle_grant got %0d exp 3", bus.grant_id); end
   endtask

   task automatic test_single();
      bus.req_valid = 3'b010;
      bus.req_addr1 = 5'd7;
      bus.req_data1 = 32'hDEADBEEF;
      #1;
      checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got %b exp 010", bus.req_ready); end
      checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL single_grant got %0d exp 1", bus.grant_id); end
      step();
      bus.req_valid = 3'b000;
      #1;
      checks++; if (bus.reg_write !== 1'b1) begin errors++; $display("FAIL single_reg_write got %b exp 1", bus.reg_write); end
      checks++; if (bus.write_reg !== 5'd7) begin errors++; $display("FAIL single_write_reg got %0d exp 7", bus.write_reg); end
      checks++; if (bus.write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write_data got %h exp deadbeef", bus.write_data); end
      checks++; if (bus.pend_mask !== 32'h00000080) begin errors++; $display("FAIL single_pend got %h exp 00000080", bus.pend_mask); end
      step();
      checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL single_n2_reg_write got %b exp 0", bus.reg_write); end
      checks++; if (bus.pend_mask !== 32'h0) begin errors++; $display("FAIL single_n2_pend got %h exp 0", bus.pend_mask); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g [9] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0};
      logic [4:0] exp_a;
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.req_addr0 = 5'd1;
      bus.req_addr1 = 5'd2;
      bus.req_addr2 = 5'd3;
      for (int i = 0; i < 9; i++) begin
         bus.req_valid = i < 6 ? 3'b111 : 3'b101;
         #1;
         checks++; if (bus.grant_id !== exp_g[i]) begin errors++; $display("FAIL rr_grant[%0d] got %0d exp %0d", i, bus.grant_id, exp_g[i]); end
         if (i > 0) begin
            exp_a = 5'(exp_g[i-1]) + 5'd1;
            checks++; if (bus.write_reg !== exp_a) begin errors++; $display("FAIL rr_write_reg[%0d] got %0d exp %0d", i, bus.write_reg, exp_a); end
         end
         step();
      end
      bus.req_valid = 3'b000;
      step();
   endtask

   task automatic test_reg0();
      bus.req_valid = 3'b100;
      bus.req_addr2 = 5'd0;
      bus.req_data2 = 32'h12345678;
      #1;
      checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL reg0_ready got %b exp 100", bus.req_ready); end
      step();
      bus.req_valid = 3'b000;
      #1;
      checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL reg0_reg_write got %b exp 0", bus.reg_write); end
      checks++; if (bus.pend_mask !== 32'h0) begin errors++; $display("FAIL reg0_pend got %h exp 0", bus.pend_mask); end
      checks++; if (bus.write_data !== 32'h12345678) begin errors++; $display("FAIL reg0_write_data got %h exp 12345678", bus.write_data); end
      step();
   endtask

   task automatic test_hold();
      bus.req_valid = 3'b001;
      bus.req_addr0 = 5'd3;
      bus.req_data0 = 32'hA5A5_0003;
      #1;
      checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL hold_pre_ready got %b exp 001", bus.req_ready); end
      step();
      hold = 1'b1;
      bus.req_valid = 3'b111;
      #1;
      checks++; if (bus.reg_write !== 1'b1) begin errors++; $display("FAIL hold_drain_reg_write got %b exp 1", bus.reg_write); end
      checks++; if (bus.write_reg !== 5'd3) begin errors++; $display("FAIL hold_drain_write_reg got %0d exp 3", bus.write_reg); end
      checks++; if (bus.pend_mask !== 32'h00000008) begin errors++; $display("FAIL hold_drain_pend got %h exp 00000008", bus.pend_mask); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL hold_ready[%0d] got %b exp 000", i, bus.req_ready); end
         checks++; if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL hold_grant[%0d] got %0d exp 3", i, bus.grant_id); end
         step();
         if (i < 2) begin
            checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL hold_idle_reg_write[%0d] got %b exp 0", i, bus.reg_write); end
         end
      end
      hold = 1'b0;
      #1;
      checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL hold_release_grant got %0d exp 1", bus.grant_id); end
      checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL hold_release_ready got %b exp 010", bus.req_ready); end
      step();
      bus.req_valid = 3'b000;
      step();
   endtask

   task automatic test_reset_mid();
      bus.req_valid = 3'b001;
      bus.req_addr0 = 5'd5;
      bus.req_data0 = 32'hCAFE_0005;
      #1;
      checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL mid_grant got %0d exp 0", bus.grant_id); end
      step();
      rst = 1'b1;
      bus.req_valid = 3'b000;
      #1;
      checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL mid_rst_reg_write got %b exp 0", bus.reg_write); end
      checks++; if (bus.pend_mask !== 32'h0) begin errors++; $display("FAIL mid_rst_pend got %h exp 0", bus.pend_mask); end
      step();
      rst = 1'b0;
      #1;
      checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL mid_after_reg_write got %b exp 0", bus.reg_write); end
      checks++; if (bus.write_reg !== 5'd0) begin errors++; $display("FAIL mid_after_write_reg got %0d exp 0", bus.write_reg); end
      bus.req_valid = 3'b111;
      #1;
      checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL mid_ptr_grant got %0d exp 0", bus.grant_id); end
      step();
      bus.req_valid = 3'b000;
      step();
   endtask

   task automatic test_back_to_back();
      bus.req_valid = 3'b011;
      bus.req_addr0 = 5'd9;
      bus.req_data0 = 32'h0000_000A;
      bus.req_addr1 = 5'd9;
      bus.req_data1 = 32'h0000_000B;
      #1;
      checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL b2b_first_grant got %0d exp 1", bus.grant_id); end
      step();
      bus.req_valid = 3'b001;
      #1;
      checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL b2b_second_grant got %0d exp 0", bus.grant_id); end
      checks++; if (bus.write_data !== 32'h0000_000B) begin errors++; $display("FAIL b2b_first_data got %h exp 0000000b", bus.write_data); end
      step();
      bus.req_valid = 3'b000;
      #1;
      checks++; if (bus.write_data !== 32'h0000_000A) begin errors++; $display("FAIL b2b_second_data got %h exp 0000000a", bus.write_data); end
      checks++; if (bus.pend_mask !== 32'h00000200) begin errors++; $display("FAIL b2b_pend got %h exp 00000200", bus.pend_mask); end
      step();
   endtask

   initial begin
      bus.req_valid = 3'b000;
      bus.req_addr0 = 5'd0;
      bus.req_addr1 = 5'd0;
      bus.req_addr2 = 5'd0;
      bus.req_data0 = 32'h0;
      bus.req_data1 = 32'h0;
      bus.req_data2 = 32'h0;
      test_reset();
      test_single();
      test_round_robin();
      test_reg0();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
